// File: rtl/cpu_datapath.sv
// Single-bus 32-bit SRC-style CPU datapath: 16 GPRs, HI/LO, Y, 64-bit Z, PC, IR, MAR, MDR,
// I/O ports, CON flip-flop and a 512x32 RAM. All control comes from outside.
module cpu_datapath #(
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  input  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
  input  logic        Gra, Grb, Grc,
  input  logic        Rin, Rout, BAout,
  input  logic        Read, IncPC, write,
  input  logic [31:0] inportInput,
  input  logic [15:0] regIn,
  output logic [31:0] busMuxOut,
  output logic [4:0]  encoderOut,
  output logic        CON,
  output logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
  output logic [31:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
  output logic [31:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
  output logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
  output logic [31:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY,
  output logic [31:0] IRregister,
  output logic [31:0] Cregister,
  output logic [8:0]  marToRam
);

  logic [31:0] r [16];
  logic [31:0] hi, lo, pc, ir, mdr, y, inport, outport;
  logic [63:0] z;
  logic [8:0]  mar;
  logic        con;
  logic [31:0] ram [512];

  logic [3:0]  idx;
  logic [25:0] req;
  logic [4:0]  enc;
  logic [31:0] bus;
  logic [31:0] c_sext;
  logic [31:0] alu_hi, alu_lo;
  logic        con_next;

  assign idx    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_sext = {{13{ir[18]}}, ir[18:0]};

  // Lowest enabled source code wins; 31 means the bus is undriven.
  always_comb begin
    req      = '0;
    req[idx] = Rout | BAout;
    req[16]  = HIout;
    req[17]  = LOout;
    req[18]  = ZHIout;
    req[19]  = ZLOout;
    req[20]  = PCout;
    req[21]  = MDRout;
    req[22]  = INPORTout;
    req[23]  = Cout;
    req[24]  = Yout;
    req[25]  = OUTPORTout;
    enc      = 5'd31;
    for (int unsigned i = 26; i > 0; i--)
      if (req[i-1]) enc = 5'(i-1);
  end

  always_comb begin
    bus = '0;
    if (enc < 5'd16) begin
      bus = (BAout && idx == 4'd0) ? '0 : r[idx];
    end else begin
      case (enc)
        5'd16:   bus = hi;
        5'd17:   bus = lo;
        5'd18:   bus = z[63:32];
        5'd19:   bus = z[31:0];
        5'd20:   bus = pc;
        5'd21:   bus = mdr;
        5'd22:   bus = inport;
        5'd23:   bus = c_sext;
        5'd24:   bus = y;
        5'd25:   bus = outport;
        default: bus = '0;
      endcase
    end
  end

  logic signed [31:0] sa, sb;
  logic        [4:0]  sh;
  logic        [63:0] prod;
  assign sa   = y;
  assign sb   = bus;
  assign sh   = bus[4:0];
  assign prod = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};

  always_comb begin
    alu_hi = '0;
    alu_lo = bus;
    case (ir[31:27])
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12,
      5'd19, 5'd20, 5'd21:  alu_lo = y + bus;
      5'd4:                 alu_lo = y - bus;
      5'd5, 5'd13:          alu_lo = y & bus;
      5'd6, 5'd14:          alu_lo = y | bus;
      5'd7:                 alu_lo = y >> sh;
      5'd8:                 alu_lo = 32'(sa >>> sh);
      5'd9:                 alu_lo = y << sh;
      5'd10:                alu_lo = (y >> sh) | (y << (6'd32 - {1'b0, sh}));
      5'd11:                alu_lo = (y << sh) | (y >> (6'd32 - {1'b0, sh}));
      5'd15:                {alu_hi, alu_lo} = prod;
      5'd16: begin
        alu_lo = '0;
        if (bus != '0) begin
          alu_lo = 32'(sa / sb);
          alu_hi = 32'(sa % sb);
        end
      end
      5'd17:                alu_lo = -bus;
      5'd18:                alu_lo = ~bus;
      default:              alu_lo = bus;
    endcase
  end

  always_comb begin
    case (ir[20:19])
      2'b00:   con_next = (bus == '0);
      2'b01:   con_next = (bus != '0);
      2'b10:   con_next = !bus[31] && (bus != '0);
      default: con_next = bus[31];
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int unsigned i = 0; i < 16; i++) r[i] <= '0;
      hi <= '0; lo <= '0; z <= '0; pc <= '0; ir <= '0; mar <= '0;
      mdr <= '0; y <= '0; inport <= '0; outport <= '0; con <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 16; i++)
        if (regIn[i] || (Rin && idx == 4'(i))) r[i] <= bus;
      if (HIin)      hi      <= bus;
      if (LOin)      lo      <= bus;
      if (Zin)       z       <= {alu_hi, alu_lo};
      if (PCin)      pc      <= IncPC ? pc + 32'd1 : bus;
      if (IRin)      ir      <= bus;
      if (MARin)     mar     <= bus[8:0];
      if (MDRin)     mdr     <= Read ? ram[mar] : bus;
      if (Yin)       y       <= bus;
      if (OUTPORTin) outport <= bus;
      if (CONin)     con     <= con_next;
      inport <= inportInput;
    end
  end

  // RAM contents survive Clear; a store writes the MDR value held before the edge.
  initial begin
    for (int unsigned i = 0; i < 512; i++) ram[i] = '0;
  end

  always_ff @(posedge Clock)
    if (write) ram[mar] <= mdr;

  assign busMuxOut  = bus;
  assign encoderOut = enc;
  assign CON        = con;
  assign BusMuxInR0  = r[0];  assign BusMuxInR1  = r[1];
  assign BusMuxInR2  = r[2];  assign BusMuxInR3  = r[3];
  assign BusMuxInR4  = r[4];  assign BusMuxInR5  = r[5];
  assign BusMuxInR6  = r[6];  assign BusMuxInR7  = r[7];
  assign BusMuxInR8  = r[8];  assign BusMuxInR9  = r[9];
  assign BusMuxInR10 = r[10]; assign BusMuxInR11 = r[11];
  assign BusMuxInR12 = r[12]; assign BusMuxInR13 = r[13];
  assign BusMuxInR14 = r[14]; assign BusMuxInR15 = r[15];
  assign BusMuxInHI      = hi;
  assign BusMuxInLO      = lo;
  assign BusMuxInZhi     = z[63:32];
  assign BusMuxInZlo     = z[31:0];
  assign BusMuxInPC      = pc;
  assign BusMuxInMDR     = mdr;
  assign BusMuxInInport  = inport;
  assign BusMuxInOutport = outport;
  assign BusMuxInY       = y;
  assign IRregister      = ir;
  assign Cregister       = c_sext;
  assign marToRam        = mar;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed and randomized checks of cpu_datapath against a behavioural model of the ISA rules.
module tb_cpu_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write;
  logic [31:0] inportInput;
  logic [15:0] regIn;
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic        CON;
  logic [31:0] gpr [16];
  logic [31:0] HIv, LOv, Zhiv, Zlov, PCv, MDRv, INv, OUTv, Yv, IRv, Cv;
  logic [8:0]  marToRam;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  cpu_datapath #(.MEM_INIT_FILE("")) dut (
    .Clock(Clock), .Clear(Clear),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout), .Cout(Cout), .Yout(Yout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .IncPC(IncPC), .write(write),
    .inportInput(inportInput), .regIn(regIn),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
    .BusMuxInR0(gpr[0]), .BusMuxInR1(gpr[1]), .BusMuxInR2(gpr[2]), .BusMuxInR3(gpr[3]),
    .BusMuxInR4(gpr[4]), .BusMuxInR5(gpr[5]), .BusMuxInR6(gpr[6]), .BusMuxInR7(gpr[7]),
    .BusMuxInR8(gpr[8]), .BusMuxInR9(gpr[9]), .BusMuxInR10(gpr[10]), .BusMuxInR11(gpr[11]),
    .BusMuxInR12(gpr[12]), .BusMuxInR13(gpr[13]), .BusMuxInR14(gpr[14]), .BusMuxInR15(gpr[15]),
    .BusMuxInHI(HIv), .BusMuxInLO(LOv), .BusMuxInZhi(Zhiv), .BusMuxInZlo(Zlov),
    .BusMuxInPC(PCv), .BusMuxInMDR(MDRv), .BusMuxInInport(INv), .BusMuxInOutport(OUTv),
    .BusMuxInY(Yv), .IRregister(IRv), .Cregister(Cv), .marToRam(marToRam)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write} = '0;
    regIn = '0;
  endtask

  task automatic step();
    @(posedge Clock); #1;
    idle();
  endtask

  // Inport samples every edge, so a value needs one edge before it can drive the bus.
  task automatic put(input logic [31:0] v);
    inportInput = v;
    @(posedge Clock); #1;
    INPORTout = 1'b1;
  endtask

  task automatic wr_ram(input logic [31:0] addr, input logic [31:0] data);
    put(addr); MARin = 1'b1; step();
    put(data); MDRin = 1'b1; step();
    write = 1'b1; step();
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    int unsigned s;
    logic [31:0] t;
    sa = a; sb = b; s = int'(b[4:0]); t = a;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19, 5'd20, 5'd21: return {32'h0, a + b};
      5'd4:        return {32'h0, a - b};
      5'd5, 5'd13: return {32'h0, a & b};
      5'd6, 5'd14: return {32'h0, a | b};
      5'd7:        return {32'h0, a >> s};
      5'd8:        return {32'h0, 32'(sa >>> s)};
      5'd9:        return {32'h0, a << s};
      5'd10: begin repeat (s) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'd11: begin repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'd15:       return 64'(longint'(sa) * longint'(sb));
      5'd16: begin
        if (b == 32'h0) return 64'h0;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      5'd17:       return {32'h0, 32'h0 - b};
      5'd18:       return {32'h0, ~b};
      default:     return {32'h0, b};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] src [26];
    logic [31:0] v_hi, v_lo, v_out, a, b, v;
    logic [4:0]  op;
    logic [1:0]  c2;
    logic [9:0]  mask;
    logic [63:0] ez;
    logic        ec;
    int          ecode;

    idle();
    inportInput = '0;
    Clear = 1'b1;
    #3;
    Clear = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("reset_R%0d", i), gpr[i], 0);
    chk("reset_HI", HIv, 0);   chk("reset_LO", LOv, 0);
    chk("reset_Zhi", Zhiv, 0); chk("reset_Zlo", Zlov, 0);
    chk("reset_PC", PCv, 0);   chk("reset_MDR", MDRv, 0);
    chk("reset_IN", INv, 0);   chk("reset_OUT", OUTv, 0);
    chk("reset_Y", Yv, 0);     chk("reset_IR", IRv, 0);
    chk("reset_CON", CON, 0);
    chk("idle_enc", encoderOut, 31);
    chk("idle_bus", busMuxOut, 0);

    put(32'd5); PCin = 1'b1; #1;
    chk("inport_bus", busMuxOut, 5);
    chk("inport_enc", encoderOut, 22);
    step();
    chk("pc_load", PCv, 5);

    wr_ram(32'd5, 32'h12200090);
    PCout = 1'b1; MARin = 1'b1; step();
    Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; step();
    chk("fetch_mdr", MDRv, 32'h12200090);
    MDRout = 1'b1; IRin = 1'b1; step();
    chk("fetch_ir", IRv, 32'h12200090);
    chk("fetch_pc", PCv, 6);
    chk("fetch_c", Cv, 32'h90);

    put(32'd22); regIn = 16'h0010; step();
    chk("st_r4", gpr[4], 22);
    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; #1;
    chk("st_enc_rb", encoderOut, 4);
    step();
    chk("st_y", Yv, 22);
    Cout = 1'b1; Zin = 1'b1; step();
    chk("st_zlo", Zlov, 32'hA6);
    chk("st_zhi", Zhiv, 0);
    ZLOout = 1'b1; MARin = 1'b1; step();
    chk("st_mar", marToRam, 166);
    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; write = 1'b1; step();
    chk("st_mdr", MDRv, 22);
    write = 1'b1; step();
    put(32'hDEAD); MDRin = 1'b1; step();
    Read = 1'b1; MDRin = 1'b1; step();
    chk("st_ram166", MDRv, 22);

    put(32'h0); IRin = 1'b1; step();
    put(32'd7); regIn = 16'h0001; step();
    chk("r0_load", gpr[0], 7);
    Grb = 1'b1; BAout = 1'b1; #1;
    chk("baout_r0_bus", busMuxOut, 0);
    chk("baout_r0_enc", encoderOut, 0);
    idle(); Grb = 1'b1; Rout = 1'b1; #1;
    chk("rout_r0_bus", busMuxOut, 7);
    idle();

    Grb = 1'b1; BAout = 1'b1; CONin = 1'b1; step();
    chk("con_eq0_true", CON, 1);
    put(32'd5); CONin = 1'b1; step();
    chk("con_eq0_false", CON, 0);

    put(32'h78000000); IRin = 1'b1; step();
    put(32'hFFFFFFFD); Yin = 1'b1; step();
    put(32'd4); Zin = 1'b1; step();
    chk("mul_zlo", Zlov, 32'hFFFFFFF4);
    chk("mul_zhi", Zhiv, 32'hFFFFFFFF);

    put(32'hFFFFFFFF); PCin = 1'b1; step();
    chk("pc_max", PCv, 32'hFFFFFFFF);
    PCin = 1'b1; IncPC = 1'b1; step();
    chk("pc_wrap", PCv, 0);

    v_hi = $urandom; v_lo = $urandom; v_out = $urandom;
    put(v_hi);  HIin = 1'b1; step();
    put(v_lo);  LOin = 1'b1; step();
    put(v_out); OUTPORTin = 1'b1; step();
    chk("hi_load", HIv, v_hi);
    chk("lo_load", LOv, v_lo);
    chk("out_load", OUTv, v_out);

    src[16] = v_hi;  src[17] = v_lo;  src[18] = 32'hFFFFFFFF; src[19] = 32'hFFFFFFF4;
    src[20] = 32'h0; src[21] = 32'd22; src[22] = v_out; src[23] = 32'h0;
    src[24] = 32'hFFFFFFFD; src[25] = v_out;
    for (int n = 0; n < 20; n++) begin
      mask = 10'($urandom);
      {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, OUTPORTout} =
        {mask[0], mask[1], mask[2], mask[3], mask[4], mask[5], mask[6], mask[7], mask[8], mask[9]};
      ecode = 31;
      for (int k = 9; k >= 0; k--) if (mask[k]) ecode = 16 + k;
      #1;
      chk($sformatf("prio_enc_%0d", n), encoderOut, 64'(ecode));
      chk($sformatf("prio_bus_%0d", n), busMuxOut, (ecode == 31) ? 64'h0 : {32'h0, src[ecode]});
      idle();
    end

    for (int n = 0; n < 48; n++) begin
      op = 5'($urandom);
      a  = $urandom;
      b  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      if (n % 12 == 0) b = 32'h0;
      if (op == 5'd16 && a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'd1;
      put({op, 27'($urandom)}); IRin = 1'b1; step();
      put(a); Yin = 1'b1; step();
      put(b); Zin = 1'b1; step();
      ez = ref_alu(op, a, b);
      chk($sformatf("alu_op%0d_zhi", op), Zhiv, ez[63:32]);
      chk($sformatf("alu_op%0d_zlo", op), Zlov, ez[31:0]);
    end

    for (int n = 0; n < 24; n++) begin
      c2 = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       v = 32'h0;
        1:       v = $urandom | 32'h80000000;
        2:       v = ($urandom & 32'h7FFFFFFF) | 32'h1;
        default: v = $urandom;
      endcase
      case (c2)
        2'b00:   ec = (v == 0);
        2'b01:   ec = (v != 0);
        2'b10:   ec = (int'(v) > 0);
        default: ec = (int'(v) < 0);
      endcase
      put({11'h0, c2, 19'h0}); IRin = 1'b1; step();
      put(v); CONin = 1'b1; step();
      chk($sformatf("con_c2_%0d_%0d", c2, n), CON, ec);
    end

    put(32'h1234); PCin = 1'b1; step();
    chk("pc_pre_clear", PCv, 32'h1234);
    Clear = 1'b1; #2;
    chk("async_clear_pc", PCv, 0);
    chk("async_clear_y", Yv, 0);
    chk("async_clear_r0", gpr[0], 0);
    Clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
